joypad_port: RTL

Serial controller-port model attached to one APU I/O port. It consumes the APU's `OUT0` strobe and the port's active-low `n_IN` read enable. It returns the serial button bit that the APU pad logic places on CPU data bit D0. Parallel load and shift-register behaviour follow the standard pad (4021-style), with an optional four-player chain mode (two pads plus signature) selected by parameter.

---
 rtl/joypad_if.sv | 21 ++
 rtl/joypad_port.sv | 59 +++++
 2 files changed

// File: rtl/joypad_if.sv
// Controller-port bus between the APU pad logic and the serial pad chain.
// The master is the APU side; the slave is the pad chain model.
interface joypad_if;
    logic       out0;
    logic       n_in;
    logic [7:0] pad0;
    logic [7:0] pad1;
    logic       d0_out;
    logic       d0_oe;
    logic [4:0] bit_cnt;

    modport master (
        output out0, n_in, pad0, pad1,
        input  d0_out, d0_oe, bit_cnt
    );

    modport slave (
        input  out0, n_in, pad0, pad1,
        output d0_out, d0_oe, bit_cnt
    );
endinterface

// File: rtl/joypad_port.sv
// 4021-style serial pad chain on one APU controller port.
// Optional four-player chain: PAD0, then PAD1, then the signature byte.
module joypad_port #(
    parameter bit         FOUR_SCORE = 1'b0,
    parameter logic [7:0] SIG        = 8'h08
) (
    input logic     i_clk,
    input logic     i_rst,
    joypad_if.slave bus
);
    localparam int         N     = FOUR_SCORE ? 24 : 8;
    localparam logic [4:0] N_CNT = 5'(N);

    logic [N-1:0] r_sr;
    logic [4:0]   r_cnt;
    logic         r_nin_q;
    logic [N-1:0] w_load_val;
    logic         w_shift;

    generate
        if (FOUR_SCORE) begin : g_four
            assign w_load_val = {SIG, bus.pad1, bus.pad0};
        end else begin : g_single
            assign w_load_val = bus.pad0;
        end
    endgenerate

    // The strobe has priority, so a read ending in a load cycle is dropped.
    assign w_shift = ~r_nin_q & bus.n_in & ~bus.out0;

    // Chain register, shift counter and end-of-read edge detector.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sr    <= '0;
            r_cnt   <= 5'd0;
            r_nin_q <= 1'b1;
        end else begin
            r_nin_q <= bus.n_in;
            if (bus.out0) begin
                r_sr  <= w_load_val;
                r_cnt <= 5'd0;
            end else if (w_shift) begin
                r_sr  <= {1'b1, r_sr[N-1:1]};
                if (r_cnt != N_CNT) begin
                    r_cnt <= r_cnt + 5'd1;
                end else begin
                    r_cnt <= r_cnt;
                end
            end else begin
                r_sr  <= r_sr;
                r_cnt <= r_cnt;
            end
        end
    end

    assign bus.d0_out  = r_sr[0] & ~bus.n_in;
    assign bus.d0_oe   = ~bus.n_in;
    assign bus.bit_cnt = r_cnt;
endmodule
